// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand-select stage.
package alu_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic SRC_B_REG = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/operand_fwd_sel.sv
// Priority forwarding selector for one source register.
// Source 0 is the youngest stage and wins over every older one; x0 is never forwarded.
module operand_fwd_sel
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_ADDR_W-1:0]         rs_addr_i,
  input  logic [XLEN-1:0]               rd_val_i,
  input  logic [NUM_FWD-1:0]            fwd_valid_i,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd_i,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data_i,
  output logic [XLEN-1:0]               val_o,
  output logic                          hit_o
);

  logic [NUM_FWD-1:0] match;

  for (genvar i = 0; i < NUM_FWD; i++) begin : g_match
    assign match[i] = fwd_valid_i[i] && (fwd_rd_i[i*REG_ADDR_W +: REG_ADDR_W] == rs_addr_i);
  end

  // Walk oldest to youngest so the lowest matching index is the last writer.
  always_comb begin
    val_o = rd_val_i;
    hit_o = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (match[i] && (rs_addr_i != '0)) begin
        val_o = fwd_data_i[i*XLEN +: XLEN];
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand-select stage: forwarding, operand muxing and a
// single-entry valid/ready pipeline register with stall and flush.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [REG_ADDR_W-1:0]         rs1_addr,
  input  logic [REG_ADDR_W-1:0]         rs2_addr,
  input  logic [XLEN-1:0]               rd1,
  input  logic [XLEN-1:0]               rd2,
  input  logic [XLEN-1:0]               imm_ext,
  input  logic [XLEN-1:0]               pc,
  input  logic [1:0]                    alu_src_a,
  input  logic                          alu_src_b,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               src_a,
  output logic [XLEN-1:0]               src_b,
  output logic [XLEN-1:0]               store_data,
  output logic [1:0]                    fwd_hit
);

  stage_state_e    state_q, state_d;
  logic            accept;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rs1_hit, rs2_hit;
  logic [XLEN-1:0] src_a_d, src_b_d;
  logic [XLEN-1:0] src_a_q, src_b_q, store_q;
  logic [1:0]      hit_q;

  operand_fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .rs_addr_i(rs1_addr), .rd_val_i(rd1), .fwd_valid_i(fwd_valid),
    .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data), .val_o(rs1_val), .hit_o(rs1_hit)
  );

  operand_fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .rs_addr_i(rs2_addr), .rd_val_i(rd2), .fwd_valid_i(fwd_valid),
    .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data), .val_o(rs2_val), .hit_o(rs2_hit)
  );

  // Ready depends only on the held entry and downstream, never on in_valid.
  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // Operand muxes sit after forwarding; reserved src_a code reads as zero.
  always_comb begin
    src_a_d = '0;
    case (alu_src_a)
      SRC_A_RS1: src_a_d = rs1_val;
      SRC_A_PC:  src_a_d = pc;
      default:   src_a_d = '0;
    endcase
    src_b_d = (alu_src_b == SRC_B_IMM) ? imm_ext : rs2_val;
  end

  // Next-state: flush dominates; FULL stays FULL on stall or pass-through.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept && !flush) state_d = ST_FULL;
      ST_FULL: begin
        if (flush)                        state_d = ST_EMPTY;
        else if (out_ready && !accept)    state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Control flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Data registers load on any accept; a flushed capture is masked by out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_a_q <= '0;
      src_b_q <= '0;
      store_q <= '0;
      hit_q   <= '0;
    end else if (accept) begin
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      store_q <= rs2_val;
      hit_q   <= {rs2_hit, rs1_hit};
    end
  end

  assign src_a      = src_a_q;
  assign src_b      = src_b_q;
  assign store_data = store_q;
  assign fwd_hit    = hit_q;

endmodule
